// File: rtl/sd_resp_pkg.sv
// Shared types and helpers for the FPGA-side sector responder.
// Write-path states exist only when SD_RESP_WRITE_EN is defined.
package sd_resp_pkg;

   localparam int         SECTOR_BYTES = 512;
   localparam logic [8:0] LAST_INDEX   = 9'(SECTOR_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE,
      ACK,
      RD_REQ,
      RD_PUT,
`ifdef SD_RESP_WRITE_EN
      WR_FETCH,
      WR_LATCH,
      WR_REQ,
`endif
      FINISH,
      REARM
   } sd_state_t;

   // A sector is servable when it lies inside the image and fits the store.
   function automatic logic in_range(input logic [31:0] lba,
                                     input logic [31:0] img_size,
                                     input int          lba_bits);
      return (lba < (img_size >> 9)) && ((lba >> lba_bits) == 32'd0);
   endfunction

endpackage

// File: rtl/sd_block_responder_if.sv
// Sector handshake plus byte-wide memory port of the block responder.
// Build option SD_RESP_WRITE_EN enables the write direction in the responder.
interface sd_block_responder_if #(
   parameter int LBA_BITS = 16,
   parameter int MEM_AW   = LBA_BITS + 9
);
   logic [31:0]       sd_lba;
   logic              sd_rd;
   logic              sd_wr;
   logic              sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic              sd_buff_wr;
   logic [7:0]        sd_buff_din;
   logic [31:0]       img_size;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_dout;
   logic [7:0]        mem_din;
   logic              mem_ready;
   logic              oob;

   // Handshakes: sd_rd/sd_wr are levels accepted only in IDLE and must drop
   // before the next accept; mem_rd/mem_wr are held with stable mem_addr and
   // mem_dout until the cycle mem_ready is high, which completes the access.
   modport master (
      output sd_lba, sd_rd, sd_wr, sd_buff_din, img_size, mem_din, mem_ready,
      input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      input  mem_addr, mem_rd, mem_wr, mem_dout, oob
   );

   modport slave (
      input  sd_lba, sd_rd, sd_wr, sd_buff_din, img_size, mem_din, mem_ready,
      output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
      output mem_addr, mem_rd, mem_wr, mem_dout, oob
   );

endinterface

// File: rtl/sd_block_responder.sv
// Serves hps_io-style sector reads/writes from a local byte-wide memory.
// SD_RESP_WRITE_EN builds the write path; without it the media is read-only.
module sd_block_responder
   import sd_resp_pkg::*;
#(
   parameter int LBA_BITS = 16,
   parameter int MEM_AW   = LBA_BITS + 9
) (
   input  logic                clk_sys,
   input  logic                reset,
   sd_block_responder_if.slave bus,
   output sd_state_t           state_dbg
);

   sd_state_t           state, state_nx;
   logic [8:0]          index, index_nx;
   logic [LBA_BITS-1:0] lba_r, lba_nx;
   logic [7:0]          data_r, data_nx;
   logic                is_rd, is_rd_nx;
   logic                oob_r, oob_nx;
   logic                last_byte;

   assign last_byte = (index == LAST_INDEX);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state  <= IDLE;
         index  <= '0;
         lba_r  <= '0;
         data_r <= '0;
         is_rd  <= 1'b0;
         oob_r  <= 1'b0;
      end else begin
         state  <= state_nx;
         index  <= index_nx;
         lba_r  <= lba_nx;
         data_r <= data_nx;
         is_rd  <= is_rd_nx;
         oob_r  <= oob_nx;
      end
   end

   always_comb begin
      state_nx = state;
      index_nx = index;
      lba_nx   = lba_r;
      data_nx  = data_r;
      is_rd_nx = is_rd;
      oob_nx   = oob_r;
      unique case (state)
         IDLE: begin
            if (bus.sd_rd || bus.sd_wr) begin
               state_nx = ACK;
               index_nx = '0;
               is_rd_nx = bus.sd_rd;
               lba_nx   = bus.sd_lba[LBA_BITS-1:0];
`ifdef SD_RESP_WRITE_EN
               oob_nx   = !in_range(bus.sd_lba, bus.img_size, LBA_BITS);
`else
               oob_nx   = !in_range(bus.sd_lba, bus.img_size, LBA_BITS) || !bus.sd_rd;
`endif
            end
         end
         ACK: begin
`ifdef SD_RESP_WRITE_EN
            state_nx = is_rd ? RD_REQ : WR_FETCH;
`else
            state_nx = is_rd ? RD_REQ : FINISH;
`endif
         end
         RD_REQ: begin
            // Out-of-range sectors read as zeros without touching memory.
            if (oob_r) begin
               data_nx  = 8'h00;
               state_nx = RD_PUT;
            end else if (bus.mem_ready) begin
               data_nx  = bus.mem_din;
               state_nx = RD_PUT;
            end
         end
         RD_PUT: begin
            if (last_byte) begin
               state_nx = FINISH;
            end else begin
               index_nx = index + 9'd1;
               state_nx = RD_REQ;
            end
         end
`ifdef SD_RESP_WRITE_EN
         WR_FETCH: state_nx = WR_LATCH;
         WR_LATCH: begin
            data_nx  = bus.sd_buff_din;
            state_nx = WR_REQ;
         end
         WR_REQ: begin
            if (oob_r || bus.mem_ready) begin
               if (last_byte) begin
                  state_nx = FINISH;
               end else begin
                  index_nx = index + 9'd1;
                  state_nx = WR_FETCH;
               end
            end
         end
`endif
         FINISH: state_nx = REARM;
         REARM: begin
            // A still-held level must not start the same sector again.
            if (!bus.sd_rd && !bus.sd_wr) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.sd_ack       = (state != IDLE) && (state != FINISH) && (state != REARM);
   assign bus.sd_buff_addr = index;
   assign bus.sd_buff_dout = data_r;
   assign bus.sd_buff_wr   = (state == RD_PUT);
   assign bus.mem_addr     = MEM_AW'({lba_r, index});
   assign bus.mem_rd       = (state == RD_REQ) && !oob_r;
   assign bus.oob          = oob_r;
   assign state_dbg        = state;

`ifdef SD_RESP_WRITE_EN
   assign bus.mem_wr   = (state == WR_REQ) && !oob_r;
   assign bus.mem_dout = data_r;
`else
   logic unused_wr_data;
   assign unused_wr_data = ^bus.sd_buff_din;
   assign bus.mem_wr     = 1'b0;
   assign bus.mem_dout   = 8'h00;
`endif

endmodule

// File: tb/tb_sd_block_responder.sv
// Bench for sd_block_responder: sector-level model, randomized memory stalls.
// Expectations follow SD_RESP_WRITE_EN the same way the design does.
module tb_sd_block_responder;
   import sd_resp_pkg::*;

   localparam int LBA_BITS = 16;
   localparam int MEM_AW   = LBA_BITS + 9;
`ifdef SD_RESP_WRITE_EN
   localparam bit WR_EN = 1'b1;
`else
   localparam bit WR_EN = 1'b0;
`endif

   // clock / reset
   logic      clk_sys = 1'b0;
   logic      reset   = 1'b1;
   sd_state_t state_dbg;
   always #5 clk_sys = ~clk_sys;

   sd_block_responder_if #(.LBA_BITS(LBA_BITS), .MEM_AW(MEM_AW)) bus ();

   sd_block_responder #(.LBA_BITS(LBA_BITS), .MEM_AW(MEM_AW)) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // scoreboard
   int vectors     = 0;
   int miscompares = 0;
   logic [16:0]       exp_buff_q[$];
   logic [MEM_AW+7:0] exp_memw_q[$];
   logic [MEM_AW-1:0] exp_memr_q[$];

   logic [7:0]        wbuf[512];
   logic [7:0]        mem_key = 8'h00;
   int                max_stall = 0, stall_total = 0, stall_left = 0;
   bit                inflight = 1'b0, ref_wr = 1'b0;
   logic [MEM_AW-1:0] ref_addr = '0;
   logic [7:0]        ref_dout = 8'h00;
   logic [8:0]        prev_buff_addr = '0;
   bit                armed = 1'b0, prev_ack = 1'b0, ack_fell = 1'b0;
   int                ack_cnt = 0, last_ack_len = 0, buff_seen = 0, memw_seen = 0;
   logic [16:0]       first_buff = '0, last_buff = '0;
   logic [MEM_AW+7:0] first_memw = '0, last_memw = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory and requester-buffer models plus the per-cycle compare process.
   always @(negedge clk_sys) begin
      if (reset) begin
         bus.mem_ready   = 1'b0;
         bus.mem_din     = 8'h00;
         bus.sd_buff_din = 8'h00;
         inflight        = 1'b0;
         prev_ack        = 1'b0;
         ack_cnt         = 0;
         prev_buff_addr  = '0;
      end else begin
         bus.sd_buff_din = wbuf[prev_buff_addr];
         prev_buff_addr  = bus.sd_buff_addr;

         if (bus.mem_rd || bus.mem_wr) begin
            check("mem_rd_wr_exclusive", 64'(bus.mem_rd & bus.mem_wr), 64'(0));
            if (!inflight) begin
               stall_left = $urandom_range(max_stall, 0);
               ref_addr   = bus.mem_addr;
               ref_dout   = bus.mem_dout;
               ref_wr     = bus.mem_wr;
               if (bus.mem_rd) begin
                  check("mem_rd_expected", 64'(exp_memr_q.size() != 0), 64'(1));
                  if (exp_memr_q.size() != 0)
                     check("mem_rd_addr", 64'(bus.mem_addr), 64'(exp_memr_q.pop_front()));
               end else begin
                  check("mem_wr_expected", 64'(exp_memw_q.size() != 0), 64'(1));
                  if (exp_memw_q.size() != 0)
                     check("mem_wr_addr_data", 64'({bus.mem_addr, bus.mem_dout}),
                           64'(exp_memw_q.pop_front()));
                  if (memw_seen == 0) first_memw = {bus.mem_addr, bus.mem_dout};
                  last_memw = {bus.mem_addr, bus.mem_dout};
                  memw_seen++;
               end
            end else begin
               check("mem_req_stable", 64'({bus.mem_wr, bus.mem_addr, bus.mem_dout}),
                     64'({ref_wr, ref_addr, ref_dout}));
            end
            if (stall_left == 0) begin
               bus.mem_ready = 1'b1;
               inflight      = 1'b0;
            end else begin
               bus.mem_ready = 1'b0;
               stall_left--;
               stall_total++;
               inflight = 1'b1;
            end
            bus.mem_din = ref_addr[7:0] ^ mem_key;
         end else begin
            if (inflight) check("mem_req_held", 64'(0), 64'(inflight));
            bus.mem_ready = 1'b0;
            inflight      = 1'b0;
         end

         if (bus.sd_buff_wr) begin
            check("buff_wr_expected", 64'(exp_buff_q.size() != 0), 64'(1));
            if (exp_buff_q.size() != 0)
               check("buff_wr_addr_data", 64'({bus.sd_buff_addr, bus.sd_buff_dout}),
                     64'(exp_buff_q.pop_front()));
            if (buff_seen == 0) first_buff = {bus.sd_buff_addr, bus.sd_buff_dout};
            last_buff = {bus.sd_buff_addr, bus.sd_buff_dout};
            buff_seen++;
         end

         if (bus.sd_ack) begin
            if (!prev_ack) check("ack_rise_requested", 64'(armed), 64'(1));
            ack_cnt++;
         end else if (prev_ack) begin
            last_ack_len = ack_cnt;
            ack_cnt      = 0;
            ack_fell     = 1'b1;
            armed        = 1'b0;
         end
         prev_ack = bus.sd_ack;
      end
   end

   // Sector-level model: what a whole request must produce.
   task automatic load_model(input bit rd, input bit wr, input logic [31:0] lba,
                             input logic [31:0] size, output int base, output bit exp_oob);
      bit in_rng, do_rd, do_wr;
      logic [MEM_AW-1:0] addr;
      in_rng  = (lba < (size / 512)) && (lba < (32'd1 << LBA_BITS));
      do_rd   = rd;
      do_wr   = !rd && wr;
      exp_oob = !in_rng || (do_wr && !WR_EN);
      for (int i = 0; i < 512; i++) begin
         addr = MEM_AW'(lba[LBA_BITS-1:0]) * 512 + MEM_AW'(i);
         if (do_rd) begin
            exp_buff_q.push_back({9'(i), in_rng ? (addr[7:0] ^ mem_key) : 8'h00});
            if (in_rng) exp_memr_q.push_back(addr);
         end
         if (do_wr && WR_EN && in_rng) exp_memw_q.push_back({addr, wbuf[i]});
      end
      base        = do_rd ? 1 + 2 * 512 : (WR_EN ? 1 + 3 * 512 : 1);
      stall_total = 0;
      buff_seen   = 0;
      memw_seen   = 0;
      ack_fell    = 1'b0;
      armed       = 1'b1;
   endtask

   task automatic flush_model();
      exp_buff_q.delete();
      exp_memw_q.delete();
      exp_memr_q.delete();
   endtask

   // driver
   task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                           input logic [31:0] size, input int stall, input int hold);
      int base;
      bit exp_oob;
      load_model(rd, wr, lba, size, base, exp_oob);
      max_stall    = stall;
      bus.sd_lba   = lba;
      bus.img_size = size;
      bus.sd_rd    = rd;
      bus.sd_wr    = wr;
      for (int c = 0; c < 12000 && !ack_fell; c++) @(negedge clk_sys);
      check("ack_fall_seen", 64'(ack_fell), 64'(1));
      check("ack_length", 64'(last_ack_len), 64'(base + stall_total));
      check("oob", 64'(bus.oob), 64'(exp_oob));
      check("buff_q_drained", 64'(exp_buff_q.size()), 64'(0));
      check("memr_q_drained", 64'(exp_memr_q.size()), 64'(0));
      check("memw_q_drained", 64'(exp_memw_q.size()), 64'(0));
      flush_model();
      repeat (hold) @(negedge clk_sys);
      bus.sd_rd = 1'b0;
      bus.sd_wr = 1'b0;
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sd_ack"},       64'(bus.sd_ack),       64'(0));
      check({tag, "_sd_buff_wr"},   64'(bus.sd_buff_wr),   64'(0));
      check({tag, "_sd_buff_addr"}, 64'(bus.sd_buff_addr), 64'(0));
      check({tag, "_sd_buff_dout"}, 64'(bus.sd_buff_dout), 64'(0));
      check({tag, "_mem_rd"},       64'(bus.mem_rd),       64'(0));
      check({tag, "_mem_wr"},       64'(bus.mem_wr),       64'(0));
      check({tag, "_mem_addr"},     64'(bus.mem_addr),     64'(0));
      check({tag, "_mem_dout"},     64'(bus.mem_dout),     64'(0));
      check({tag, "_oob"},          64'(bus.oob),          64'(0));
      check({tag, "_state"},        64'(state_dbg),        64'(IDLE));
   endtask

   initial begin
      bit   rd, wr;
      int   sectors, base;
      bit   exp_oob;
      logic [31:0] lba, size;

      bus.sd_lba   = '0;
      bus.sd_rd    = 1'b0;
      bus.sd_wr    = 1'b0;
      bus.img_size = '0;
      for (int i = 0; i < 512; i++) wbuf[i] = 8'h00;
      repeat (3) @(negedge clk_sys);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk_sys);

      // Plain read: byte i of sector 3 is i, 1025-cycle ack.
      mem_key = 8'h00;
      run_xfer(1'b1, 1'b0, 32'd3, 32'h0001_0000, 0, 2);
      check("rd3_ack_len_literal", 64'(last_ack_len), 64'(1025));
      check("rd3_first_byte", 64'(first_buff), 64'({9'h000, 8'h00}));
      check("rd3_last_byte", 64'(last_buff), 64'({9'h1FF, 8'hFF}));
      check("rd3_oob_literal", 64'(bus.oob), 64'(0));

      // Write sector 5 with buffer bytes ~index.
      for (int i = 0; i < 512; i++) wbuf[i] = ~8'(i);
      run_xfer(1'b0, 1'b1, 32'd5, 32'h0001_0000, 0, 2);
`ifdef SD_RESP_WRITE_EN
      check("wr5_ack_len_literal", 64'(last_ack_len), 64'(1537));
      check("wr5_first_mem", 64'(first_memw), 64'({25'h0000A00, 8'hFF}));
      check("wr5_last_mem", 64'(last_memw), 64'({25'h0000BFF, 8'h00}));
      check("wr5_oob_literal", 64'(bus.oob), 64'(0));
`else
      check("wr5_ack_len_literal", 64'(last_ack_len), 64'(1));
      check("wr5_no_mem_wr", 64'(memw_seen), 64'(0));
      check("wr5_oob_literal", 64'(bus.oob), 64'(1));
`endif

      // Out-of-range read returns zeros.
      mem_key = 8'h5A;
      run_xfer(1'b1, 1'b0, 32'd200, 32'h0001_0000, 0, 2);
      check("rd200_oob_literal", 64'(bus.oob), 64'(1));
      check("rd200_last_byte", 64'(last_buff), 64'({9'h1FF, 8'h00}));

      // Sector-count boundary and high LBA bits.
      run_xfer(1'b1, 1'b0, 32'd127, 32'h0001_01FF, 0, 2);
      run_xfer(1'b1, 1'b0, 32'd128, 32'h0001_01FF, 0, 2);
      run_xfer(1'b1, 1'b0, 32'h0001_0003, 32'hFFFF_FFFF, 0, 2);

      // Memory stalls in both directions.
      mem_key = 8'hC3;
      run_xfer(1'b1, 1'b0, 32'd9, 32'h0002_0000, 7, 2);
      for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
      run_xfer(1'b0, 1'b1, 32'd17, 32'h0002_0000, 7, 2);

      // Held request is served once; read wins over write.
      run_xfer(1'b1, 1'b0, 32'd1, 32'h0001_0000, 0, 20);
      run_xfer(1'b1, 1'b1, 32'd2, 32'h0001_0000, 3, 2);

      // Reset in the middle of a read, then a clean read.
      load_model(1'b1, 1'b0, 32'd7, 32'h0001_0000, base, exp_oob);
      max_stall    = 2;
      bus.sd_lba   = 32'd7;
      bus.img_size = 32'h0001_0000;
      bus.sd_rd    = 1'b1;
      for (int c = 0; c < 4000 && buff_seen <= 100; c++) @(negedge clk_sys);
      check("midreset_reached_byte100", 64'(buff_seen > 100), 64'(1));
      reset     = 1'b1;
      bus.sd_rd = 1'b0;
      @(negedge clk_sys);
      check_reset_outputs("midreset");
      reset = 1'b0;
      flush_model();
      armed = 1'b0;
      repeat (2) @(negedge clk_sys);
      run_xfer(1'b1, 1'b0, 32'd7, 32'h0001_0000, 1, 2);

      // Randomized requests around the image limit.
      for (int t = 0; t < 8; t++) begin
         rd      = 1'($urandom_range(1, 0));
         wr      = rd ? 1'($urandom_range(1, 0)) : 1'b1;
         sectors = $urandom_range(300, 1);
         size    = (32'(sectors) << 9) | 32'($urandom_range(511, 0));
         lba     = 32'($urandom_range(sectors + 20, 0));
         if ($urandom_range(9, 0) == 0) lba = lba | 32'h0001_0000;
         for (int i = 0; i < 512; i++) wbuf[i] = 8'($urandom);
         mem_key = 8'($urandom);
         run_xfer(rd, wr, lba, size, $urandom_range(7, 0), $urandom_range(4, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
